// File: rtl/cnt_arb_pkg.sv
// Shared constants and FSM encoding for the two-requester counter arbiter.
package cnt_arb_pkg;

   localparam int CNT_W    = 5;
   localparam int CNT_TERM = 7;

   localparam logic signed [CNT_W-1:0] TERM_VAL = CNT_W'(CNT_TERM);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cnt_arb_ctrl_if.sv
// Request/grant bundle between requesters and the counter arbiter.
interface cnt_arb_ctrl_if import cnt_arb_pkg::*; ();

   // Handshake: req[i] is a level held until done (with done_id == i) or
   // withdrawn; gnt is one-hot ownership; done qualifies done_id for one cycle.
   logic [1:0]              req;
   logic signed [CNT_W-1:0] start0;
   logic signed [CNT_W-1:0] start1;
   logic [1:0]              gnt;
   logic                    busy;
   logic signed [CNT_W-1:0] cnt_val;
   logic                    done;
   logic                    done_id;
   state_t                  state;

   modport master (
      output req, start0, start1,
      input  gnt, busy, cnt_val, done, done_id, state
   );

   modport slave (
      input  req, start0, start1,
      output gnt, busy, cnt_val, done, done_id, state
   );

endinterface

// File: rtl/cnt_core.sv
// Signed shared counter: clr beats load, load beats inc.
module cnt_core import cnt_arb_pkg::*; #(
   parameter int W = CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic signed [W-1:0] load_val,
   input  logic                inc,
   input  logic                clr,
   output logic signed [W-1:0] val
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         val <= '0;
      else if (load)
         val <= load_val;
      else if (inc)
         val <= val + W'(1);
   end

endmodule

// File: rtl/cnt_arb_ctrl.sv
// Two-requester arbiter owning a shared counter; define CNT_ARB_RR_EN for
// round-robin on simultaneous requests, otherwise requester 0 has priority.
module cnt_arb_ctrl import cnt_arb_pkg::*; (
   input  logic           clk,
   input  logic           rst,
   cnt_arb_ctrl_if.slave  bus
);

   state_t                  state_q, state_d;
   logic                    owner_q, owner_d;
   logic [1:0]              gnt_q, gnt_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    done_id_q, done_id_d;
   logic                    winner;
   logic                    load, inc, clr;
   logic signed [CNT_W-1:0] load_val;
   logic signed [CNT_W-1:0] cnt;

`ifdef CNT_ARB_RR_EN
   logic last_owner_q, last_owner_d;

   assign winner = (bus.req == 2'b11) ? ~last_owner_q : bus.req[1];

   always_ff @(posedge clk) begin
      if (rst)
         last_owner_q <= 1'b1;
      else
         last_owner_q <= last_owner_d;
   end
`else
   assign winner = ~bus.req[0];
`endif

   assign load_val = winner ? bus.start1 : bus.start0;

   cnt_core #(.W(CNT_W)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .inc      (inc),
      .clr      (clr),
      .val      (cnt)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      load      = 1'b0;
      inc       = 1'b0;
      clr       = 1'b0;
`ifdef CNT_ARB_RR_EN
      last_owner_d = last_owner_q;
`endif
      case (state_q)
         IDLE: begin
            gnt_d  = 2'b00;
            busy_d = 1'b0;
            if (|bus.req) begin
               state_d = RUN;
               owner_d = winner;
               load    = 1'b1;
               gnt_d   = winner ? 2'b10 : 2'b01;
               busy_d  = 1'b1;
`ifdef CNT_ARB_RR_EN
               last_owner_d = winner;
`endif
            end
         end
         RUN: begin
            // Withdrawal wins over completion so an abandoned run never reports done.
            if (!bus.req[owner_q]) begin
               state_d = IDLE;
               clr     = 1'b1;
               gnt_d   = 2'b00;
               busy_d  = 1'b0;
            end else if (cnt >= TERM_VAL) begin
               state_d   = DONE;
               clr       = 1'b1;
               gnt_d     = 2'b00;
               busy_d    = 1'b1;
               done_d    = 1'b1;
               done_id_d = owner_q;
            end else begin
               inc = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            clr     = 1'b1;
            gnt_d   = 2'b00;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.cnt_val = cnt;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_cnt_arb_ctrl.sv
// Directed scoreboard bench for cnt_arb_ctrl: expected runs are queued by the
// driver, and a negedge monitor checks each grant, count step and run ending.
module tb_cnt_arb_ctrl;
   import cnt_arb_pkg::*;

   localparam int EXP_W = 17;

   logic clk = 1'b0;
   logic rst;

   cnt_arb_ctrl_if bus ();

   cnt_arb_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // {gap_chk, gap[2:0], aborted, len[5:0], id, start[4:0]}
   logic [EXP_W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   logic mon_en = 1'b0;

   function automatic logic [EXP_W-1:0] pack(input logic id, input int start,
                                             input int len, input logic aborted,
                                             input int gap);
      logic       gap_chk;
      logic [2:0] gap_f;
      gap_chk = (gap >= 0);
      gap_f   = gap_chk ? 3'(gap) : 3'd0;
      return {gap_chk, gap_f, aborted, 6'(len), id, 5'(start)};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // sel: 0 = cnt_val equals v, 1 = any grant, 2 = done pulse
   task automatic wait_for(input int sel, input int v, input string name);
      int  n;
      bit  hit;
      hit = 1'b0;
      for (n = 0; n < 100 && !hit; n++) begin
         @(negedge clk);
         case (sel)
            0:       hit = (int'(bus.cnt_val) == v);
            1:       hit = (bus.gnt != 2'b00);
            default: hit = bus.done;
         endcase
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL timeout_%s: condition not reached in 100 cycles", name);
      end
   endtask

   // Monitor
   logic [1:0]       prev_gnt = 2'b00;
   logic [EXP_W-1:0] cur;
   bit               have_cur = 1'b0;
   int               k = 0;
   int               zero_cnt = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
            k = 0;
            if (exp_q.size() == 0) begin
               have_cur = 1'b0;
               check("unexpected_grant", int'(bus.gnt), 0);
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1'b1;
               check("grant_id", int'(bus.gnt), cur[5] ? 2 : 1);
               check("load_val", int'(bus.cnt_val), int'($signed(cur[4:0])));
               check("run_busy", int'(bus.busy), 1);
               if (cur[16])
                  check("idle_gap", zero_cnt, int'(cur[15:13]));
            end
         end else if (bus.gnt != 2'b00) begin
            k++;
            if (have_cur) begin
               check("count_step", int'(bus.cnt_val), int'($signed(cur[4:0])) + k);
               check("grant_hold", int'(bus.gnt), cur[5] ? 2 : 1);
            end
         end else if (prev_gnt != 2'b00) begin
            if (have_cur) begin
               check("run_len", k + 1, int'(cur[11:6]));
               check("cnt_cleared", int'(bus.cnt_val), 0);
               if (cur[12]) begin
                  check("abort_no_done", int'(bus.done), 0);
                  check("abort_busy", int'(bus.busy), 0);
               end else begin
                  check("done_pulse", int'(bus.done), 1);
                  check("done_id", int'(bus.done_id), int'(cur[5]));
                  check("done_busy", int'(bus.busy), 1);
               end
            end
            have_cur = 1'b0;
         end else begin
            check("idle_done", int'(bus.done), 0);
            check("idle_busy", int'(bus.busy), 0);
            check("idle_cnt", int'(bus.cnt_val), 0);
         end
         zero_cnt = (bus.gnt == 2'b00) ? zero_cnt + 1 : 0;
         prev_gnt = bus.gnt;
      end
   end

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      bus.req    = 2'b00;
      bus.start0 = '0;
      bus.start1 = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", int'(bus.gnt), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_cnt", int'(bus.cnt_val), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_done_id", int'(bus.done_id), 0);
      check("rst_state", int'(bus.state), int'(IDLE));
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Single run from -10; start0 changed mid-run must not matter
      exp_q.push_back(pack(1'b0, -10, 18, 1'b0, -1));
      bus.start0 = -5'sd10;
      bus.req    = 2'b01;
      wait_for(1, 0, "gnt_single");
      bus.start0 = 5'sd15;
      wait_for(2, 0, "done_single");
      bus.req = 2'b00;
      repeat (3) @(negedge clk);

      // Terminal boundaries on requester 1
      exp_q.push_back(pack(1'b1, 7, 1, 1'b0, -1));
      bus.start1 = 5'sd7;
      bus.req    = 2'b10;
      wait_for(2, 0, "done_start7");
      bus.req = 2'b00;
      repeat (3) @(negedge clk);
      exp_q.push_back(pack(1'b1, 15, 1, 1'b0, -1));
      bus.start1 = 5'sd15;
      bus.req    = 2'b10;
      wait_for(2, 0, "done_start15");
      bus.req = 2'b00;
      repeat (3) @(negedge clk);

      // Abort by owner 1 at cnt_val=2 with requester 0 pending
      exp_q.push_back(pack(1'b1, 0, 3, 1'b1, -1));
      bus.start1 = 5'sd0;
      bus.start0 = 5'sd4;
      bus.req    = 2'b10;
      wait_for(1, 0, "gnt_abort");
      bus.req = 2'b11;
      wait_for(0, 2, "cnt2_abort");
      exp_q.push_back(pack(1'b0, 4, 4, 1'b0, 1));
      bus.req = 2'b01;
      wait_for(2, 0, "done_after_abort");
      bus.req = 2'b00;
      repeat (3) @(negedge clk);

      // Reset mid-run at cnt_val=-3, then req sampled on first edge after reset
      exp_q.push_back(pack(1'b0, -10, 8, 1'b1, -1));
      bus.start0 = -5'sd10;
      bus.req    = 2'b01;
      wait_for(0, -3, "cnt_m3");
      rst = 1'b1;
      exp_q.push_back(pack(1'b0, 3, 5, 1'b0, 1));
      @(negedge clk);
      rst        = 1'b0;
      bus.start0 = 5'sd3;
      wait_for(2, 0, "done_after_rst");
      bus.req = 2'b00;
      repeat (3) @(negedge clk);

      // Contention with req=11 held, from a fresh reset
      do_reset();
      @(negedge clk);
      bus.start0 = 5'sd5;
      bus.start1 = 5'sd5;
`ifdef CNT_ARB_RR_EN
      exp_q.push_back(pack(1'b0, 5, 3, 1'b0, -1));
      exp_q.push_back(pack(1'b1, 5, 3, 1'b0, 2));
      exp_q.push_back(pack(1'b0, 5, 3, 1'b0, 2));
`else
      exp_q.push_back(pack(1'b0, 5, 3, 1'b0, -1));
      exp_q.push_back(pack(1'b0, 5, 3, 1'b0, 2));
      exp_q.push_back(pack(1'b0, 5, 3, 1'b0, 2));
`endif
      bus.req = 2'b11;
      for (int i = 0; i < 3; i++)
         wait_for(2, 0, "done_contention");
      bus.req = 2'b00;
      repeat (5) @(negedge clk);

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
